axi_xdma_st_data_check_s_axis: RTL

// AXI-Stream slave that consumes the data generator's stream directly (M_AXIS -> S_AXIS) and checks it.

---
 rtl/axi_xdma_st_data_check_s_axis.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi_xdma_st_data_check_s_axis.sv
// AXI-Stream checker for the XDMA data generator: verifies counter sequences and TLAST
// framing, throttles TREADY with a rotating pattern, and exports saturating status counters.
module axi_xdma_st_data_check_s_axis #(
  parameter int C_S_AXIS_TDATA_WIDTH  = 128,
  parameter int NUMBER_OF_INPUT_WORDS = 64
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic [31:0]                       config_reg0,
  input  logic [31:0]                       config_reg1,
  input  logic [31:0]                       config_reg2,
  output logic [31:0]                       status_beat_count,
  output logic [31:0]                       status_pkt_count,
  output logic [31:0]                       status_data_err_count,
  output logic [31:0]                       status_frame_err_count,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   status_first_err_data,
  output logic                              status_err_flag
);

  localparam int W     = C_S_AXIS_TDATA_WIDTH;
  localparam int N     = NUMBER_OF_INPUT_WORDS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((N > 0) ? N - 1 : 0);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_RAND = 2'b11;

  typedef enum logic [1:0] {ST_DISABLED, ST_SYNC, ST_CHECK} state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [W-1:0] next_val(input logic [W-1:0] x, input logic [1:0] m,
                                            input logic [W-1:0] s);
    case (m)
      MODE_UP:   return x + s;
      MODE_DOWN: return x - s;
      default:   return x;
    endcase
  endfunction

  logic [1:0]   mode;
  logic         enable, clr;
  logic [7:0]   pattern;
  logic [W-1:0] step_w;
  logic         acc, data_err, frame_err, last_pos;
  logic         cfg_unused;

  state_t       state_q, state_d;
  logic [7:0]   thr_q, thr_d;
  logic         tready_q, tready_d;
  logic [1:0]   mode_q;
  logic [W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]  beat_q, beat_d, pkt_q, pkt_d, derr_q, derr_d, ferr_q, ferr_d;
  logic [W-1:0] first_q, first_d;
  logic         flag_q, flag_d;

  assign mode       = config_reg0[1:0];
  assign enable     = config_reg0[4];
  assign clr        = config_reg0[5];
  assign pattern    = config_reg0[15:8];
  assign step_w     = W'({config_reg2, config_reg1});
  assign cfg_unused = ^{config_reg0[31:16], config_reg0[7:6], config_reg0[3:2]};
  assign acc        = S_AXIS_TVALID & tready_q;
  assign last_pos   = (idx_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    thr_d     = {thr_q[0], thr_q[7:1]};
    exp_d     = exp_q;
    idx_d     = idx_q;
    data_err  = 1'b0;
    frame_err = 1'b0;
    tready_d  = enable & ~thr_q[0] & (state_q != ST_DISABLED);
    if (!enable) begin
      state_d = ST_DISABLED;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_DISABLED: begin
          state_d = ST_SYNC;
          thr_d   = pattern;
        end
        ST_SYNC: begin
          if (acc) begin
            exp_d   = next_val(S_AXIS_TDATA, mode, step_w);
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // A mode switch invalidates exp, so this cycle's beat is not compared.
          if (mode != mode_q) begin
            state_d = ST_SYNC;
            thr_d   = pattern;
          end else if (acc) begin
            data_err = (S_AXIS_TSTRB != '1) ||
                       ((mode != MODE_RAND) && (S_AXIS_TDATA != exp_q));
            exp_d    = next_val(S_AXIS_TDATA, mode, step_w);
          end
        end
        default: state_d = ST_DISABLED;
      endcase
      if (acc && (state_q != ST_DISABLED) && (N != 0)) begin
        frame_err = S_AXIS_TLAST ? !last_pos : last_pos;
        idx_d     = (S_AXIS_TLAST || last_pos) ? '0 : idx_q + IDX_W'(1);
      end
    end

    beat_d  = acc ? sat_inc(beat_q) : beat_q;
    pkt_d   = (acc && S_AXIS_TLAST) ? sat_inc(pkt_q) : pkt_q;
    derr_d  = data_err ? sat_inc(derr_q) : derr_q;
    ferr_d  = frame_err ? sat_inc(ferr_q) : ferr_q;
    first_d = (data_err && (derr_q == 32'd0)) ? S_AXIS_TDATA : first_q;
    flag_d  = flag_q | data_err | frame_err;
    if (clr) begin
      beat_d  = '0;
      pkt_d   = '0;
      derr_d  = '0;
      ferr_d  = '0;
      first_d = '0;
      flag_d  = 1'b0;
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q  <= ST_DISABLED;
      thr_q    <= '0;
      tready_q <= 1'b0;
      mode_q   <= '0;
      exp_q    <= '0;
      idx_q    <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      derr_q   <= '0;
      ferr_q   <= '0;
      first_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      tready_q <= tready_d;
      mode_q   <= mode;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      derr_q   <= derr_d;
      ferr_q   <= ferr_d;
      first_q  <= first_d;
      flag_q   <= flag_d;
    end
  end

  assign S_AXIS_TREADY          = tready_q;
  assign status_beat_count      = beat_q;
  assign status_pkt_count       = pkt_q;
  assign status_data_err_count  = derr_q;
  assign status_frame_err_count = ferr_q;
  assign status_first_err_data  = first_q;
  assign status_err_flag        = flag_q;

endmodule
